// File: rtl/tt_um_izaiahthigpen_prbs31_chk_if.sv
// Tiny Tapeout pin bundle for the PRBS31 checker: dedicated inputs, outputs and bidir pins.
interface tt_um_izaiahthigpen_prbs31_chk_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport master (
    output ui_in, uio_in, ena,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ui_in, uio_in, ena,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_izaiahthigpen_prbs31_chk.sv
// PRBS31 (x^31+x^28+1) serial checker: seed/verify acquisition, flywheel lock,
// saturating error and loss-of-lock counters.
module tt_um_izaiahthigpen_prbs31_chk (
  input  logic clk,
  input  logic rst_n,
  tt_um_izaiahthigpen_prbs31_chk_if.slave bus
);

  localparam logic [1:0] ST_SEED   = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCK   = 2'b10;

  logic rx_bit, rx_valid, clr_err, resync, byte_sel;
  assign rx_bit   = bus.ui_in[0];
  assign rx_valid = bus.ui_in[1];
  assign clr_err  = bus.ui_in[2];
  assign resync   = bus.ui_in[3];
  assign byte_sel = bus.ui_in[4];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ui_in[7:5], bus.uio_in, bus.ena};

  logic [30:0] s;
  logic [1:0]  state;
  logic [4:0]  bit_cnt;
  logic [5:0]  win_cnt;
  logic [3:0]  win_err;
  logic [15:0] err_cnt;
  logic [3:0]  loss_cnt;
  logic        lock;
  logic        err_pulse;

  logic [30:0] s_nx;
  logic [1:0]  state_nx;
  logic [4:0]  bit_cnt_nx;
  logic [5:0]  win_cnt_nx;
  logic [3:0]  win_err_nx;
  logic [15:0] err_cnt_nx;
  logic [3:0]  loss_cnt_nx;
  logic        err_pulse_nx;

  logic pred, mismatch;
  assign pred     = s[30] ^ s[27];
  assign mismatch = rx_bit ^ pred;

  always_comb begin
    s_nx         = s;
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    win_cnt_nx   = win_cnt;
    win_err_nx   = win_err;
    err_cnt_nx   = err_cnt;
    loss_cnt_nx  = loss_cnt;
    err_pulse_nx = 1'b0;
    if (rx_valid) begin
      if (resync) begin
        state_nx   = ST_SEED;
        bit_cnt_nx = '0;
        win_cnt_nx = '0;
        win_err_nx = '0;
      end else begin
        case (state)
          ST_SEED: begin
            s_nx = {s[29:0], rx_bit};
            if (bit_cnt == 5'd30) begin
              state_nx   = ST_VERIFY;
              bit_cnt_nx = '0;
            end else begin
              bit_cnt_nx = bit_cnt + 5'd1;
            end
          end
          ST_VERIFY: begin
            s_nx = {s[29:0], rx_bit};
            if (mismatch) begin
              state_nx   = ST_SEED;
              bit_cnt_nx = '0;
            end else if (bit_cnt == 5'd31) begin
              state_nx   = ST_LOCK;
              bit_cnt_nx = '0;
              win_cnt_nx = '0;
              win_err_nx = '0;
            end else begin
              bit_cnt_nx = bit_cnt + 5'd1;
            end
          end
          ST_LOCK: begin
            // Flywheel: regenerate locally so received errors never corrupt s.
            s_nx       = {s[29:0], pred};
            win_cnt_nx = win_cnt + 6'd1;
            if (mismatch) begin
              err_pulse_nx = 1'b1;
              if (err_cnt != '1) err_cnt_nx = err_cnt + 16'd1;
            end
            if (mismatch && win_err == 4'd7) begin
              state_nx   = ST_SEED;
              bit_cnt_nx = '0;
              win_cnt_nx = '0;
              win_err_nx = '0;
              if (loss_cnt != '1) loss_cnt_nx = loss_cnt + 4'd1;
            end else if (win_cnt == 6'd63) begin
              win_err_nx = '0;
            end else if (mismatch) begin
              win_err_nx = win_err + 4'd1;
            end
          end
          default: begin
            state_nx   = ST_SEED;
            bit_cnt_nx = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
          end
        endcase
      end
      if (clr_err) err_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      state     <= ST_SEED;
      bit_cnt   <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_cnt   <= '0;
      loss_cnt  <= '0;
      lock      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      s         <= s_nx;
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      win_cnt   <= win_cnt_nx;
      win_err   <= win_err_nx;
      err_cnt   <= err_cnt_nx;
      loss_cnt  <= loss_cnt_nx;
      lock      <= (state_nx == ST_LOCK);
      err_pulse <= err_pulse_nx;
    end
  end

  assign bus.uo_out  = {loss_cnt, state, err_pulse, lock};
  assign bus.uio_out = byte_sel ? err_cnt[15:8] : err_cnt[7:0];
  assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_izaiahthigpen_prbs31_chk.sv
// Self-checking bench for the PRBS31 checker: directed acquisition/lock-loss
// sequences, a vector table around error counting, and randomized model comparison.
module tb_tt_um_izaiahthigpen_prbs31_chk;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tt_um_izaiahthigpen_prbs31_chk_if bus ();

  tt_um_izaiahthigpen_prbs31_chk dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: acquisition progress as a single run length, history as a queue.
  int m_state, m_run, m_win, m_werr, m_err, m_loss;
  bit m_pulse;
  bit m_hist[$];
  bit [30:0] gen;

  typedef struct {
    bit         inv;
    bit         clr;
    bit         sel;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;
  vec_t tbl[11];

  function automatic bit next_bit();
    bit nb;
    nb  = gen[30] ^ gen[27];
    gen = {gen[29:0], nb};
    return nb;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_run = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_loss = 0; m_pulse = 0;
    m_hist.delete();
    for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void push_hist(bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(bit b, bit v, bit clr, bit rsy);
    bit pred;
    m_pulse = 0;
    if (!v) return;
    pred = m_hist[0] ^ m_hist[3];
    if (rsy) begin
      m_state = 0; m_run = 0; m_win = 0; m_werr = 0;
    end else if (m_state == 0) begin
      push_hist(b);
      m_run++;
      if (m_run == 31) m_state = 1;
    end else if (m_state == 1) begin
      push_hist(b);
      if (b != pred) begin
        m_state = 0; m_run = 0;
      end else begin
        m_run++;
        if (m_run == 63) begin
          m_state = 2; m_win = 0; m_werr = 0;
        end
      end
    end else begin
      push_hist(pred);
      if (b != pred) begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
        m_werr++;
      end
      m_win++;
      if (m_werr == 8) begin
        m_state = 0; m_run = 0;
        if (m_loss < 15) m_loss++;
      end else if (m_win == 64) begin
        m_win = 0; m_werr = 0;
      end
    end
    if (clr) m_err = 0;
  endfunction

  function automatic logic [7:0] model_uo();
    logic [3:0] l;
    logic [1:0] st;
    l  = 4'(m_loss);
    st = 2'(m_state);
    return {l, st, m_pulse, (m_state == 2)};
  endfunction

  function automatic logic [7:0] model_uio(bit sel);
    logic [15:0] e;
    e = 16'(m_err);
    return sel ? e[15:8] : e[7:0];
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
  task automatic step(input bit b, input bit v, input bit clr, input bit rsy, input bit sel);
    bus.ui_in = {3'b000, sel, rsy, clr, v, b};
    @(posedge clk);
    model_step(b, v, clr, rsy);
    @(negedge clk);
    check8("model_uo_out", bus.uo_out, model_uo());
    check8("model_uio_out", bus.uio_out, model_uio(sel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check8("reset_uo_out", bus.uo_out, 8'h00);
    check8("reset_uio_out", bus.uio_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check8("reset_uio_oe", bus.uio_oe, 8'hFF);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit b, v, inv, clr, rsy, sel;
    int nv, budget, rate;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h01};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h09, 8'h01};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h02};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h03};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h09, 8'h03};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h04};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h05};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h09, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h0B, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h09, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h0B, 8'h01};

    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    bus.ena    = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Clean stream from seed 1: lock on the 63rd bit, no errors over 10000 bits.
    gen = 31'd1;
    for (int i = 1; i <= 10000; i++) begin
      step(next_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 30) check8("seed_at_30", bus.uo_out, 8'h00);
      if (i == 31) check8("verify_at_31", bus.uo_out, 8'h04);
      if (i == 62) check8("no_lock_at_62", bus.uo_out, 8'h04);
      if (i == 63) check8("lock_at_63", bus.uo_out, 8'h09);
    end
    check8("err_cnt_clean_lo", bus.uio_out, 8'h00);

    // Single errors, clear-vs-error collision and byte select while locked.
    for (int i = 0; i < 11; i++) begin
      b = next_bit() ^ tbl[i].inv;
      step(b, 1'b1, tbl[i].clr, 1'b0, tbl[i].sel);
      check8($sformatf("tbl%0d_uo_out", i), bus.uo_out, tbl[i].exp_uo);
      check8($sformatf("tbl%0d_uio_out", i), bus.uio_out, tbl[i].exp_uio);
    end

    // Resync while locked drops lock immediately without counting a loss.
    step(next_bit(), 1'b1, 1'b0, 1'b1, 1'b0);
    check8("resync_uo_out", bus.uo_out, 8'h00);
    for (int i = 1; i <= 63; i++) begin
      step(next_bit(), 1'b1, (i == 1), 1'b0, 1'b0);
      if (i == 62) check8("resync_no_lock_62", bus.uo_out, 8'h04);
    end
    check8("resync_relock_uo", bus.uo_out, 8'h09);
    check8("resync_relock_err", bus.uio_out, 8'h00);

    // Eight errors inside one window: loss on the 8th, relock 63 bits later.
    for (int k = 0; k <= 14; k++) begin
      b = next_bit() ^ (k % 2 == 0);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 12) check8("seventh_err_still_locked", bus.uo_out, 8'h0B);
    end
    check8("loss_uo_out", bus.uo_out, 8'h12);
    check8("loss_err_cnt", bus.uio_out, 8'h08);
    for (int i = 1; i <= 63; i++) begin
      step(next_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 62) check8("relock_not_yet", bus.uo_out, 8'h14);
    end
    check8("relock_after_loss", bus.uo_out, 8'h19);

    // Asynchronous reset in the middle of a cycle while locked.
    #2;
    do_reset();

    // Error during VERIFY at bit 40.
    gen = 31'd1;
    for (int i = 1; i <= 110; i++) begin
      b = next_bit() ^ (i == 40);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 40) check8("verify_err_to_seed", bus.uo_out, 8'h00);
      if (i == 102) check8("verify_err_no_lock_102", bus.uo_out, 8'h04);
      if (i == 103) begin
        check8("verify_err_lock_103", bus.uo_out, 8'h09);
        check8("verify_err_cnt", bus.uio_out, 8'h00);
      end
    end

    // 50% gapped valid: lock on the 63rd valid bit.
    do_reset();
    gen = 31'd1;
    nv = 0;
    budget = 0;
    while (nv < 63 && budget < 1000) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        b = next_bit();
        nv++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(b, v, 1'b0, 1'b0, 1'b0);
      if (v && nv == 62) check8("gapped_no_lock_62", bus.uo_out, 8'h04);
      budget++;
    end
    check8("gapped_lock_63", bus.uo_out, (nv == 63) ? 8'h09 : 8'hEE);

    // Randomized traffic with error bursts, clears and resyncs.
    do_reset();
    gen = 31'($urandom) | 31'd1;
    for (int i = 0; i < 5000; i++) begin
      rate = ((i / 500) % 3 == 2) ? 6 : 40;
      v    = ($urandom_range(0, 3) != 0);
      inv  = ($urandom_range(0, rate - 1) == 0);
      clr  = ($urandom_range(0, 199) == 0);
      rsy  = ($urandom_range(0, 299) == 0);
      sel  = 1'($urandom_range(0, 1));
      b    = v ? (next_bit() ^ inv) : 1'($urandom_range(0, 1));
      step(b, v, clr, rsy, sel);
    end
    check8("final_uio_oe", bus.uio_oe, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_um_izaiahthigpen_prbs31_chk.md
TT_UM_IZAIAHTHIGPEN_PRBS31_CHK -- requirements
Module: tt_um_izaiahthigpen_prbs31_chk

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port ui_in, input, 8:
- [0] rx_bit, serial PRBS31 data
- [1] rx_valid, sample rx_bit this edge
- [2] clr_err, synchronous error-counter clear
- [3] resync, force reacquisition
- [4] byte_sel
- [7:5] unused
REQ-004 SHALL have port uo_out, output, 8:
- [0] lock
- [1] err_pulse
- [3:2] state code
- [7:4] loss_cnt
REQ-005 SHALL have port uio_out, output, 8; err_cnt byte: low byte when byte_sel=0, high byte when byte_sel=1.
REQ-006 SHALL have port uio_oe, output, 8; constant 8'hFF.
REQ-007 SHALL have ports uio_in (input, 8) and ena (input, 1); both ignored.

Function
REQ-008 SHALL check polynomial x^31+x^28+1; 31-bit shift register s, s[0] newest; predicted bit p = s[30]^s[27].
REQ-009 SHALL act only on edges with rx_valid=1; when rx_valid=0, all state holds and err_pulse=0.
REQ-010 SHALL implement FSM SEED(code 00), VERIFY(01), LOCK(10); code 11 unused, recovers to SEED.
REQ-011 SEED: shift rx_bit into s; 5-bit bit counter counts to 31, then enter VERIFY with counter cleared.
REQ-012 VERIFY: compare rx_bit to p and shift rx_bit into s.
- Mismatch: enter SEED, counter cleared; err_cnt untouched.
- 32 consecutive matches: enter LOCK.
REQ-013 LOCK (flywheel): shift p, not rx_bit, into s.
- On mismatch: err_pulse=1 for that cycle; err_cnt+1.
REQ-014 err_cnt SHALL be 16 bits, saturating at 16'hFFFF; counts only in LOCK.
REQ-015 LOCK SHALL keep a 6-bit window counter (64 valid bits) and a 4-bit window error count.
- Both cleared on LOCK entry and at each window wrap (63->0).
REQ-016 Loss of lock:
- Trigger: 8th error within one window.
- Same edge: enter SEED, increment loss_cnt, and still count that error in err_cnt.
- loss_cnt is 4-bit, saturating at 4'hF.
REQ-017 lock SHALL equal (state==LOCK), registered; it rises at the edge sampling the 63rd valid bit after SEED entry with an error-free stream.
REQ-018 resync=1 SHALL force SEED at that edge, overriding all other transitions.
- bit, window and window-error counters cleared; loss_cnt not incremented.
REQ-019 clr_err=1 SHALL set err_cnt to 0.
- Clear wins over a simultaneous error; err_pulse still asserts for that error.
- clr_err SHALL NOT clear loss_cnt.
REQ-020 All outputs except the combinational uio_out byte mux SHALL be direct register outputs.

Reset
REQ-021 rst_n=0 SHALL immediately set:
- state=SEED, s=0, all counters=0
- lock=0, err_pulse=0
- uo_out=8'h00, uio_out=8'h00
REQ-022 Deassertion SHALL enter SEED; reset mid-LOCK discards lock, err_cnt and loss_cnt.

Verification
REQ-023 Clean PRBS31 stream from seed 31'd1, rx_valid=1 -> lock=1 at 63rd valid edge, state code 10; err_cnt=0 after 10000 bits.
REQ-024 Locked, one bit inverted -> exactly one err_pulse cycle; err_cnt=1; lock stays 1.
REQ-025 Locked, 8 inverted bits within one 64-bit window -> lock=0 at 8th error edge; err_cnt=8; loss_cnt=1; relock 63 bits later.
REQ-026 Error in VERIFY (bit 40 inverted) -> state returns to SEED; err_cnt=0; lock at bit 40+63.
REQ-027 Locked with err_cnt=5; clr_err and an error on the same edge -> err_cnt=0, err_pulse=1; byte_sel toggles uio_out low/high byte.
REQ-028 rx_valid gapped 50% -> lock at 63rd valid bit; resync while locked -> lock=0 next edge, loss_cnt unchanged.
